// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, access size codes, rw_len field positions,
// idle RAM code, requester ids and the local alignment check.

package ram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   // rw_len[1:0] size field
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // rw_len[2] selects a write
   localparam int RW_WRITE_BIT = 2;

   // Code presented to the RAM whenever no access is being issued
   localparam logic [2:0] RW_IDLE = 3'b000;

   // Instruction fetches are always word reads
   localparam logic [2:0] RW_IF_FETCH = 3'b010;

   // Requester ids, also the encoding of the round-robin last_grant bit
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_LS = 1'b1;

   // Misaligned half/word or the reserved size code.
   function automatic logic access_err(input logic [1:0] size,
                                       input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      case (size)
         SZ_B:    err = 1'b0;
         SZ_H:    err = addr_lo[0];
         SZ_W:    err = (addr_lo != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of request, response and RAM-side signals of the data-RAM arbiter.
// Latency: n/a (wires only).
// Backpressure: requests stall on *_req_ready; responses are never stalled.
//
// Ports: IF request/response, LS request/response, RAM rw_len/addr/write
// out and read/exception back. The slave modport is the arbiter's view,
// the master modport is the view of the surrounding core and RAM.

interface ram_port_arbiter_if #(
   parameter int ADDR_W = 11
);

   // instruction fetch
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_rsp_valid;
   logic [31:0]       if_rsp_data;
   logic              if_rsp_err;

   // load/store
   logic              ls_req_valid;
   logic              ls_req_ready;
   logic [ADDR_W-1:0] ls_addr;
   logic [2:0]        ls_rw_len;
   logic [31:0]       ls_wdata;
   logic              ls_rsp_valid;
   logic [31:0]       ls_rsp_data;
   logic              ls_rsp_err;

   // RAM port
   logic [2:0]        ram_rw_len;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_write;
   logic [31:0]       ram_read;
   logic              ram_exception;

   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  ls_req_valid, ls_addr, ls_rw_len, ls_wdata,
      output ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      output ram_rw_len, ram_addr, ram_write,
      input  ram_read, ram_exception
   );

   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
      output ls_req_valid, ls_addr, ls_rw_len, ls_wdata,
      input  ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      input  ram_rw_len, ram_addr, ram_write,
      output ram_read, ram_exception
   );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter holding the last_grant bit.
// Latency: grants are combinational from the requests; last_grant updates on the next edge.
// Backpressure: grants are suppressed while en is low; a grant is a completed handshake.
//
// Ports: clk, rst_n; en (owner can accept now); req_if/req_ls request
// valids; gnt_if/gnt_ls one-hot grants.

module ram_rr_arb2
   import ram_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_if,
   input  logic req_ls,
   output logic gnt_if,
   output logic gnt_ls
);

   logic last_grant_q;
   logic last_grant_d;
   logic pick_if;

   always_comb begin
      pick_if      = 1'b0;
      gnt_if       = 1'b0;
      gnt_ls       = 1'b0;
      last_grant_d = last_grant_q;

      // IF wins when alone, or on a tie when LS was served last
      pick_if = req_if && (!req_ls || (last_grant_q == REQ_LS));
      gnt_if  = en && pick_if;
      gnt_ls  = en && req_ls && !pick_if;

      if (gnt_if) begin
         last_grant_d = REQ_IF;
      end else if (gnt_ls) begin
         last_grant_d = REQ_LS;
      end
   end

   // Resetting to LS lets IF win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= REQ_LS;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates IF and LS onto the single-port data RAM, one access at a time.
// Latency: handshake in N, RAM driven in N+1, rsp_valid pulse in N+2 (one access per 3 cycles).
// Backpressure: ready is low outside IDLE; responses are single-cycle pulses and cannot stall.
//
// Ports: clk, rst_n (async, active low); bus (slave modport) carrying the
// IF and LS request/response channels and the RAM rw_len/addr/write/read/
// exception port.

module ram_port_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = 11
)(
   input  logic                 clk,
   input  logic                 rst_n,
   ram_port_arbiter_if.slave    bus
);

   // FSM
   state_e state_q, state_d;

   // Latched request: only what the response path needs. The full
   // address and write data go straight into the RAM drive registers.
   logic       id_q,      id_d;
   logic [2:0] rw_q,      rw_d;
   logic [1:0] addr_lo_q, addr_lo_d;

   // Response registers
   logic [31:0] data_q, data_d;
   logic        err_q,  err_d;

   // RAM drive registers. They hold a real access only during ISSUE and
   // the idle code otherwise, so the RAM sees flop outputs and never a
   // decoded or input-derived write enable.
   logic [2:0]        ram_rw_q,   ram_rw_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wr_q,   ram_wr_d;

   // Arbiter
   logic arb_en;
   logic gnt_if;
   logic gnt_ls;

   // Incoming request muxed from the winner
   logic [2:0]        in_rw;
   logic [ADDR_W-1:0] in_addr;
   logic [31:0]       in_wdata;
   logic              in_err;
   logic              lat_err;

   // Response steering
   logic rsp_if;
   logic rsp_ls;

   assign arb_en = (state_q == ST_IDLE);

   ram_rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (arb_en),
      .req_if (bus.if_req_valid),
      .req_ls (bus.ls_req_valid),
      .gnt_if (gnt_if),
      .gnt_ls (gnt_ls)
   );

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      rw_d       = rw_q;
      addr_lo_d  = addr_lo_q;
      data_d     = data_q;
      err_d      = err_q;
      ram_rw_d   = RW_IDLE;
      ram_addr_d = '0;
      ram_wr_d   = '0;

      in_rw    = gnt_if ? RW_IF_FETCH  : bus.ls_rw_len;
      in_addr  = gnt_if ? bus.if_addr  : bus.ls_addr;
      in_wdata = gnt_if ? 32'h0        : bus.ls_wdata;
      in_err   = access_err(in_rw[1:0], in_addr[1:0]);
      lat_err  = access_err(rw_q[1:0], addr_lo_q);

      case (state_q)
         ST_IDLE: begin
            if (gnt_if || gnt_ls) begin
               id_d      = gnt_if ? REQ_IF : REQ_LS;
               rw_d      = in_rw;
               addr_lo_d = in_addr[1:0];
               data_d    = 32'h0;
               err_d     = 1'b0;
               // A faulty request never reaches the RAM, so a misaligned
               // write cannot corrupt memory even if the RAM would not trap it.
               if (!in_err) begin
                  ram_rw_d   = in_rw;
                  ram_addr_d = in_addr;
                  ram_wr_d   = in_wdata;
               end
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (lat_err) begin
               data_d = 32'h0;
               err_d  = 1'b1;
            end else begin
               data_d = rw_q[RW_WRITE_BIT] ? 32'h0 : bus.ram_read;
               err_d  = err_q | bus.ram_exception;
            end
            state_d = ST_RESP;
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         id_q       <= REQ_IF;
         rw_q       <= RW_IDLE;
         addr_lo_q  <= 2'b00;
         data_q     <= 32'h0;
         err_q      <= 1'b0;
         ram_rw_q   <= RW_IDLE;
         ram_addr_q <= '0;
         ram_wr_q   <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         rw_q       <= rw_d;
         addr_lo_q  <= addr_lo_d;
         data_q     <= data_d;
         err_q      <= err_d;
         ram_rw_q   <= ram_rw_d;
         ram_addr_q <= ram_addr_d;
         ram_wr_q   <= ram_wr_d;
      end
   end

   // Only the requester that owns the in-flight access sees any response
   // activity; the other port stays at zero.
   assign rsp_if = (state_q == ST_RESP) && (id_q == REQ_IF);
   assign rsp_ls = (state_q == ST_RESP) && (id_q == REQ_LS);

   assign bus.if_req_ready = gnt_if;
   assign bus.ls_req_ready = gnt_ls;

   assign bus.if_rsp_valid = rsp_if;
   assign bus.if_rsp_data  = rsp_if ? data_q : 32'h0;
   assign bus.if_rsp_err   = rsp_if & err_q;

   assign bus.ls_rsp_valid = rsp_ls;
   assign bus.ls_rsp_data  = rsp_ls ? data_q : 32'h0;
   assign bus.ls_rsp_err   = rsp_ls & err_q;

   assign bus.ram_rw_len = ram_rw_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_write  = ram_wr_q;

endmodule
